// File: rtl/ram_transfer_scheduler_if.sv
// ----------------------------------------------------------------------------
// ram_transfer_scheduler_if
//
// Bundles the requester-side handshake and the engine-side command bus of the
// RAM transfer scheduler.
//
//   Requester side : req, req_dir, req_rd_addr, req_wr_addr, req_chunks (in),
//                    ack, done, busy, err (out)
//   Engine side    : command, read_write_command, read_address,
//                    write_address, no_of_chunks (out), interupt (in)
//
// Modports:
//   slave  - the scheduler itself (consumes requests, drives the engine)
//   master - the environment (requesters plus the transfer engine)
// ----------------------------------------------------------------------------
interface ram_transfer_scheduler_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 6
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_dir;
    logic [NUM_REQ*ADDR_W-1:0] req_rd_addr;
    logic [NUM_REQ*ADDR_W-1:0] req_wr_addr;
    logic [NUM_REQ*2-1:0]      req_chunks;
    logic [NUM_REQ-1:0]        ack;
    logic [NUM_REQ-1:0]        done;
    logic                      busy;
    logic                      err;
    logic                      command;
    logic                      read_write_command;
    logic [ADDR_W-1:0]         read_address;
    logic [ADDR_W-1:0]         write_address;
    logic [1:0]                no_of_chunks;
    logic                      interupt;

    modport slave (
        input  req, req_dir, req_rd_addr, req_wr_addr, req_chunks, interupt,
        output ack, done, busy, err, command, read_write_command,
               read_address, write_address, no_of_chunks
    );

    modport master (
        output req, req_dir, req_rd_addr, req_wr_addr, req_chunks, interupt,
        input  ack, done, busy, err, command, read_write_command,
               read_address, write_address, no_of_chunks
    );
endinterface

// File: rtl/ram_transfer_scheduler.sv
// ----------------------------------------------------------------------------
// ram_transfer_scheduler
//
// Round-robin arbiter/sequencer in front of the single RAM<->ECC transfer
// engine. One requester is granted at a time; its direction, addresses and
// chunk count are latched into the engine output registers, a one-cycle
// command strobe starts the engine, and the engine's interupt pulse is turned
// into a one-hot done pulse back to the granted requester.
//
// Sequence: IDLE -> ISSUE -> WAIT -> DONE -> GAP -> IDLE
//
// Ports:
//   clk    - system clock, all logic on the rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - ram_transfer_scheduler_if.slave (requests, acks/dones, engine bus)
//
// Optional feature (macro TRANSFER_TIMEOUT_EN):
//   When defined, a watchdog counts WAIT cycles; reaching TIMEOUT_CYCLES
//   without interupt forces DONE with err pulsed alongside done. When not
//   defined, WAIT waits indefinitely and err stays 0.
// ----------------------------------------------------------------------------
module ram_transfer_scheduler #(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_W         = 6,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    ram_transfer_scheduler_if.slave  bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   gnt_q, gnt_d;
    logic               rw_q, rw_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [1:0]         chunks_q, chunks_d;
    logic               err_q, err_d;

    logic               timeout_hit;

    // ------------------------------------------------------------------------
    // Round-robin winner search
    // ------------------------------------------------------------------------
    // The request vector is doubled and rotated so that bit 0 of req_rot is
    // requester rr_ptr; the first set bit then gives the distance from rr_ptr.
    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [IDX_W-1:0]     win_idx;
    logic                 win_found;
    logic [IDX_W:0]       win_sum;

    always_comb begin
        req_dbl   = {bus.req, bus.req};
        req_rot   = req_dbl[rr_ptr_q +: NUM_REQ];
        win_idx   = '0;
        win_found = 1'b0;
        win_sum   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found && req_rot[i]) begin
                win_found = 1'b1;
                win_sum   = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
                if (win_sum >= NUM_REQ_W) begin
                    win_sum = win_sum - NUM_REQ_W;
                end
                win_idx = win_sum[IDX_W-1:0];
            end
        end
    end

    // Fields of the winning requester, selected with constant slices
    logic              win_dir;
    logic [ADDR_W-1:0] win_rd_addr;
    logic [ADDR_W-1:0] win_wr_addr;
    logic [1:0]        win_chunks;

    always_comb begin
        win_dir     = 1'b0;
        win_rd_addr = '0;
        win_wr_addr = '0;
        win_chunks  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDX_W'(i)) begin
                win_dir     = bus.req_dir[i];
                win_rd_addr = bus.req_rd_addr[i*ADDR_W +: ADDR_W];
                win_wr_addr = bus.req_wr_addr[i*ADDR_W +: ADDR_W];
                win_chunks  = bus.req_chunks[i*2 +: 2];
            end
        end
    end

    // Pointer advance: the requester after the current grant gets first look
    logic [IDX_W:0]   gnt_inc;
    logic [IDX_W-1:0] gnt_next;

    always_comb begin
        gnt_inc  = {1'b0, gnt_q} + (IDX_W+1)'(1);
        gnt_next = gnt_inc[IDX_W-1:0];
        if (gnt_inc >= NUM_REQ_W) begin
            gnt_next = '0;
        end
    end

    // ------------------------------------------------------------------------
    // WAIT watchdog
    // ------------------------------------------------------------------------
`ifdef TRANSFER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // Cleared while in ISSUE so the first WAIT cycle sees zero; the limit is
    // hit on the TIMEOUT_CYCLES-th WAIT cycle, so DONE lands exactly
    // TIMEOUT_CYCLES cycles after WAIT was entered.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == S_ISSUE) begin
            tmo_cnt_d = '0;
        end else if (state_q == S_WAIT) begin
            tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign timeout_hit = (state_q == S_WAIT) &&
                         (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout_hit        = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_d     = gnt_q;
        rw_d      = rw_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        chunks_d  = chunks_q;
        err_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    gnt_d     = win_idx;
                    rw_d      = win_dir;
                    rd_addr_d = win_rd_addr;
                    wr_addr_d = win_wr_addr;
                    chunks_d  = win_chunks;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                rr_ptr_d = gnt_next;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                // A real completion takes priority over a coincident timeout
                if (bus.interupt) begin
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_GAP;
            end
            S_GAP: begin
                // Gives the engine its write-disable/clear cycle before the
                // next command can be issued.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and engine output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= '0;
            gnt_q     <= '0;
            rw_q      <= 1'b0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            chunks_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            gnt_q     <= gnt_d;
            rw_q      <= rw_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            chunks_q  <= chunks_d;
            err_q     <= err_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // ack only in ISSUE and done only in DONE, so they can never coincide.
    always_comb begin
        bus.ack  = '0;
        bus.done = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.ack[i]  = (state_q == S_ISSUE) && (gnt_q == IDX_W'(i));
            bus.done[i] = (state_q == S_DONE)  && (gnt_q == IDX_W'(i));
        end
    end

    assign bus.command            = (state_q == S_ISSUE);
    assign bus.busy               = (state_q != S_IDLE);
    assign bus.err                = err_q;
    assign bus.read_write_command = rw_q;
    assign bus.read_address       = rd_addr_q;
    assign bus.write_address      = wr_addr_q;
    assign bus.no_of_chunks       = chunks_q;

endmodule

// File: tb/tb_ram_transfer_scheduler.sv
// ----------------------------------------------------------------------------
// tb_ram_transfer_scheduler
//
// Directed bench for ram_transfer_scheduler (NUM_REQ=2, ADDR_W=6,
// TIMEOUT_CYCLES=16). Inputs change and outputs are sampled 1 ns after the
// rising clock edge; the engine's interupt is driven by hand.
// ----------------------------------------------------------------------------
module tb_ram_transfer_scheduler;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 6;

    logic clk;
    logic rst_n;

    int vectors;
    int miscompares;

    ram_transfer_scheduler_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W)) sif ();

    ram_transfer_scheduler #(
        .NUM_REQ        (NUM_REQ),
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".busy"},    32'(sif.busy),               32'h0);
        check({tag, ".command"}, 32'(sif.command),            32'h0);
        check({tag, ".ack"},     32'(sif.ack),                32'h0);
        check({tag, ".done"},    32'(sif.done),               32'h0);
        check({tag, ".err"},     32'(sif.err),                32'h0);
        check({tag, ".rw"},      32'(sif.read_write_command), 32'h0);
        check({tag, ".rd"},      32'(sif.read_address),       32'h0);
        check({tag, ".wr"},      32'(sif.write_address),      32'h0);
        check({tag, ".chunks"},  32'(sif.no_of_chunks),       32'h0);
    endtask

    initial begin
        int exp_w;
        vectors     = 0;
        miscompares = 0;

        rst_n           = 1'b0;
        sif.req         = '0;
        sif.req_dir     = '0;
        sif.req_rd_addr = '0;
        sif.req_wr_addr = '0;
        sif.req_chunks  = '0;
        sif.interupt    = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick();
        check("post_reset.busy", 32'(sif.busy), 32'h0);

        // ---------------- single request ----------------
        sif.req         = 2'b01;
        sif.req_dir     = 2'b01;
        sif.req_rd_addr = {6'h00, 6'h05};
        sif.req_wr_addr = {6'h00, 6'h10};
        sif.req_chunks  = {2'b00, 2'b11};
        tick();                                   // latched -> ISSUE
        check("t1.command", 32'(sif.command),            32'h1);
        check("t1.ack",     32'(sif.ack),                32'h1);
        check("t1.rd",      32'(sif.read_address),       32'h05);
        check("t1.wr",      32'(sif.write_address),      32'h10);
        check("t1.chunks",  32'(sif.no_of_chunks),       32'h3);
        check("t1.rw",      32'(sif.read_write_command), 32'h1);
        check("t1.busy",    32'(sif.busy),               32'h1);
        check("t1.done",    32'(sif.done),               32'h0);
        sif.req = 2'b00;
        tick();                                   // WAIT, command+1
        check("t1.wait_command", 32'(sif.command), 32'h0);
        check("t1.wait_ack",     32'(sif.ack),     32'h0);
        check("t1.wait_rd",      32'(sif.read_address), 32'h05);
        repeat (5) tick();                        // command+6
        check("t1.wait_done", 32'(sif.done), 32'h0);
        sif.interupt = 1'b1;
        tick();                                   // DONE
        sif.interupt = 1'b0;
        check("t1.done_pulse", 32'(sif.done), 32'h1);
        check("t1.done_ack",   32'(sif.ack),  32'h0);
        check("t1.done_err",   32'(sif.err),  32'h0);
        tick();                                   // GAP
        check("t1.gap_done", 32'(sif.done), 32'h0);
        check("t1.gap_busy", 32'(sif.busy), 32'h1);
        tick();                                   // IDLE
        check("t1.idle_busy", 32'(sif.busy), 32'h0);

        // ---------------- both held, alternating grants ----------------
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sif.req         = 2'b11;
        sif.req_dir     = 2'b10;
        sif.req_rd_addr = {6'h02, 6'h01};
        sif.req_wr_addr = {6'h22, 6'h21};
        sif.req_chunks  = {2'b10, 2'b01};
        for (int t = 0; t < 4; t++) begin
            exp_w = t % 2;
            tick();                               // ISSUE
            check("rr.command", 32'(sif.command),            32'h1);
            check("rr.ack",     32'(sif.ack),                32'(1 << exp_w));
            check("rr.rd",      32'(sif.read_address),       (exp_w == 1) ? 32'h02 : 32'h01);
            check("rr.wr",      32'(sif.write_address),      (exp_w == 1) ? 32'h22 : 32'h21);
            check("rr.rw",      32'(sif.read_write_command), 32'(exp_w));
            check("rr.chunks",  32'(sif.no_of_chunks),       (exp_w == 1) ? 32'h2 : 32'h1);
            tick();                               // WAIT
            check("rr.wait_command", 32'(sif.command), 32'h0);
            tick();
            check("rr.wait_command2", 32'(sif.command), 32'h0);
            sif.interupt = 1'b1;
            tick();                               // DONE
            sif.interupt = 1'b0;
            check("rr.done", 32'(sif.done), 32'(1 << exp_w));
            check("rr.done_ack", 32'(sif.ack), 32'h0);
            tick();                               // GAP
            check("rr.gap_command", 32'(sif.command), 32'h0);
            tick();                               // IDLE
            check("rr.idle_busy", 32'(sif.busy), 32'h0);
        end

        // ---------------- request arrives during WAIT ----------------
        sif.req         = 2'b01;
        sif.req_dir     = 2'b10;
        sif.req_rd_addr = {6'h33, 6'h0A};
        sif.req_wr_addr = {6'h3C, 6'h1A};
        sif.req_chunks  = {2'b01, 2'b00};
        tick();                                   // ISSUE for req0
        check("late.ack0",    32'(sif.ack),          32'h1);
        check("late.rd0",     32'(sif.read_address), 32'h0A);
        check("late.chunks0", 32'(sif.no_of_chunks), 32'h0);
        sif.req = 2'b00;
        tick();                                   // WAIT
        tick();
        sif.req = 2'b10;
        tick();
        check("late.wait_command", 32'(sif.command),      32'h0);
        check("late.wait_rd",      32'(sif.read_address), 32'h0A);
        check("late.wait_rw",      32'(sif.read_write_command), 32'h0);
        tick();
        sif.interupt = 1'b1;
        tick();                                   // DONE
        sif.interupt = 1'b0;
        check("late.done0",       32'(sif.done),    32'h1);
        check("late.done_command", 32'(sif.command), 32'h0);
        tick();                                   // GAP
        check("late.gap_command", 32'(sif.command), 32'h0);
        check("late.gap_ack",     32'(sif.ack),     32'h0);
        tick();                                   // IDLE
        check("late.idle_command", 32'(sif.command), 32'h0);
        tick();                                   // ISSUE for req1
        check("late.command1", 32'(sif.command),            32'h1);
        check("late.ack1",     32'(sif.ack),                32'h2);
        check("late.rd1",      32'(sif.read_address),       32'h33);
        check("late.wr1",      32'(sif.write_address),      32'h3C);
        check("late.rw1",      32'(sif.read_write_command), 32'h1);
        check("late.chunks1",  32'(sif.no_of_chunks),       32'h1);
        sif.req = 2'b00;
        tick();                                   // WAIT
        sif.interupt = 1'b1;
        tick();                                   // DONE
        sif.interupt = 1'b0;
        check("late.done1", 32'(sif.done), 32'h2);
        tick();
        tick();

        // ---------------- reset in the middle of WAIT ----------------
        sif.req = 2'b01;
        tick();                                   // ISSUE req0, rr_ptr -> 1
        check("rstw.ack", 32'(sif.ack), 32'h1);
        sif.req = 2'b00;
        tick();
        tick();                                   // in WAIT
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rstw.async");
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        sif.interupt = 1'b1;
        tick();
        sif.interupt = 1'b0;
        check("rstw.no_done", 32'(sif.done), 32'h0);
        check("rstw.idle",    32'(sif.busy), 32'h0);
        tick();
        check("rstw.no_done2", 32'(sif.done), 32'h0);
        sif.req = 2'b11;
        tick();                                   // ISSUE from rr_ptr=0
        check("rstw.ack_after", 32'(sif.ack),          32'h1);
        check("rstw.rd_after",  32'(sif.read_address), 32'h0A);
        sif.req = 2'b00;
        tick();
        sif.interupt = 1'b1;
        tick();
        sif.interupt = 1'b0;
        check("rstw.done_after", 32'(sif.done), 32'h1);
        tick();
        tick();
        check("rstw.idle_after", 32'(sif.busy), 32'h0);

        // ---------------- interupt never arrives ----------------
        sif.req = 2'b01;
        tick();                                   // ISSUE
        check("tmo.ack", 32'(sif.ack), 32'h1);
        sif.req = 2'b00;
        tick();                                   // first WAIT cycle
        repeat (15) tick();
        check("tmo.pre_busy", 32'(sif.busy), 32'h1);
        check("tmo.pre_done", 32'(sif.done), 32'h0);
        check("tmo.pre_err",  32'(sif.err),  32'h0);
        tick();                                   // 16 cycles after WAIT entry
`ifdef TRANSFER_TIMEOUT_EN
        check("tmo.err",  32'(sif.err),  32'h1);
        check("tmo.done", 32'(sif.done), 32'h1);
        tick();
        check("tmo.err_clear", 32'(sif.err), 32'h0);
        tick();
        check("tmo.idle", 32'(sif.busy), 32'h0);
        sif.req = 2'b10;
        tick();
        check("tmo.new_ack", 32'(sif.ack), 32'h2);
        sif.req = 2'b00;
        tick();
        sif.interupt = 1'b1;
        tick();
        sif.interupt = 1'b0;
        check("tmo.new_done", 32'(sif.done), 32'h2);
        check("tmo.new_err",  32'(sif.err),  32'h0);
        tick();
        tick();
`else
        check("tmo.busy", 32'(sif.busy), 32'h1);
        check("tmo.err",  32'(sif.err),  32'h0);
        check("tmo.done", 32'(sif.done), 32'h0);
        repeat (8) tick();
        check("tmo.busy_late", 32'(sif.busy), 32'h1);
        check("tmo.err_late",  32'(sif.err),  32'h0);
        sif.interupt = 1'b1;
        tick();
        sif.interupt = 1'b0;
        check("tmo.final_done", 32'(sif.done), 32'h1);
        tick();
        tick();
        check("tmo.final_idle", 32'(sif.busy), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_transfer_scheduler.md
Name: ram_transfer_scheduler

Overview:
- Arbitrates and sequences transfer requests between the outer RAM and the ECC RAM through the single Ram_data_transfer engine.
- Accepts up to NUM_REQ requesters, each presenting direction, read/write addresses and chunk count.
- Grants round-robin and issues exactly one engine command at a time.
- Waits for the engine's completion interrupt, then returns a per-requester done pulse.

Parameters:
- NUM_REQ, 2, number of requesters (1..4).
- ADDR_W, 6, RAM address width; matches the engine's adbus width.
- TIMEOUT_CYCLES, 16, watchdog limit in WAIT; used only with TRANSFER_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request; held high until ack.
- req_dir  in  NUM_REQ  per-requester direction; 1 = ECC->RAM, 0 = RAM->ECC.
- req_rd_addr  in  NUM_REQ*ADDR_W  packed read addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wr_addr  in  NUM_REQ*ADDR_W  packed write addresses.
- req_chunks  in  NUM_REQ*2  packed chunk counts, forwarded unchanged.
- ack  out  NUM_REQ  one-cycle accept pulse, one-hot.
- done  out  NUM_REQ  one-cycle completion pulse, one-hot.
- busy  out  1  high whenever state is not IDLE.
- err  out  1  one-cycle timeout pulse.
- command  out  1  engine start strobe, exactly one cycle.
- read_write_command  out  1  to engine; latched req_dir.
- read_address  out  ADDR_W  to engine.
- write_address  out  ADDR_W  to engine.
- no_of_chunks  out  2  to engine.
- interupt  in  1  engine completion pulse.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; rr_ptr=0; grant index=0.
  - All outputs 0, including command, ack, done, busy, err and all engine address/chunk buses.
  - Reset mid-transfer abandons the transfer without a done pulse. An engine interupt arriving after reset is ignored, because IDLE ignores interupt.
- State machine: IDLE -> ISSUE -> WAIT -> DONE -> GAP -> IDLE.
  - IDLE: if any req bit is set, pick the winner by round-robin starting at rst_ptr index rr_ptr (search rr_ptr, rr_ptr+1, ... modulo NUM_REQ). Register the winner index and its dir/addresses/chunks into the engine output registers, then go to ISSUE. If req==0, stay in IDLE.
  - ISSUE (1 cycle): command=1, ack[winner]=1; rr_ptr <= winner+1 mod NUM_REQ; go to WAIT. The requester may drop req or change its fields from the next cycle.
  - WAIT: command=0. Engine outputs stay stable for the whole transfer. On interupt=1, go to DONE.
  - DONE (1 cycle): done[winner]=1; go to GAP.
  - GAP (1 cycle): idle cycle that lets the engine complete its write-disable/clear state; go to IDLE.
- Latency:
  - req rising in IDLE -> winner latched at the next edge -> command/ack one cycle later.
  - interupt -> done one cycle later.
  - Minimum spacing between command pulses is 5 cycles plus the engine duration.
- Fairness: a requester that holds req continuously is granted at most once per NUM_REQ grants while the others are requesting.
- Simultaneous events:
  - A new req during WAIT/DONE/GAP is only sampled in IDLE.
  - An interupt outside WAIT is ignored.
  - ack and done are never asserted in the same cycle.
- A req that drops before it is granted is simply not served. There is no error for this.
- Address and chunk fields are passed through without arithmetic. Chunk count 00 is forwarded as-is; the engine treats it as one chunk.

Optional Feature:
- Macro: TRANSFER_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES before interupt, go to DONE with done[winner]=1 and err=1 in the same cycle.
  - If interupt and the timeout occur in the same cycle, interupt wins and err=0.
- Undefined: WAIT lasts indefinitely, err is tied to 0, and the counter is absent.

Test Plan:
- Reset then single request: req=01, dir0=1, rd=6'h05, wr=6'h10, chunks=2'b11; engine model raises interupt 6 cycles after command.
  -> command pulses once with read_address=05, write_address=10, no_of_chunks=3, read_write_command=1; ack[0] on the same cycle; done[0] exactly 1 cycle after interupt; busy low 2 cycles after done.
- Both requesters held continuously for 4 transfers.
  -> grant order 0,1,0,1; each ack one-hot; no overlapping command while busy.
- Request arrives during WAIT: req1 rises 2 cycles into req0's transfer.
  -> no second command until GAP completes; then req1 is granted with its own fields, which are unaffected by req0's fields.
- Reset mid-WAIT: rst_n=0 for 1 cycle, then interupt pulses.
  -> all outputs 0 immediately; no done pulse; state IDLE; next req served normally from rr_ptr=0.
- With TRANSFER_TIMEOUT_EN and TIMEOUT_CYCLES=16: interupt never arrives.
  -> err=1 and done[winner]=1 on the same cycle, 16 cycles after entering WAIT; the scheduler accepts a new request afterwards.
- Without the macro: same stimulus.
  -> busy stays high and err stays 0.
